// File: rtl/if_id_skid_reg.sv
// IF->ID pipeline register with valid/ready handshake.
// Two-entry buffer (main + skid) gives full throughput while in_ready depends
// only on registered state. Supports flush (squash) and bubble insertion, and
// keeps a saturating count of decode stall cycles for profiling.
module if_id_skid_reg #(
    parameter int              INSTR_W   = 32,
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_3000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter int              CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc4,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc4,
    output logic [CNT_W-1:0]   stall_cnt
);

    // Main entry feeds decode; skid entry catches the word in flight on a stall.
    logic               mv;
    logic [INSTR_W-1:0] m_instr;
    logic [PC_W-1:0]    m_pc4;
    logic               sv;
    logic [INSTR_W-1:0] s_instr;
    logic [PC_W-1:0]    s_pc4;

    logic in_fire;
    logic out_fire;

    // The skid flag is a flop, so in_ready never sees out_ready combinationally.
    assign in_ready  = ~sv;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = mv & out_ready;

    assign out_valid = mv;
    assign out_pc4   = m_pc4;
    assign out_instr = mv ? m_instr : NOP_INSTR;

    // Buffer control: reset beats flush, flush beats normal transfer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mv      <= 1'b0;
            sv      <= 1'b0;
            m_instr <= NOP_INSTR;
            m_pc4   <= RESET_PC;
            s_instr <= NOP_INSTR;
            s_pc4   <= RESET_PC;
        end else if (flush) begin
            // A same-cycle input is accepted and discarded; pc4 is left alone.
            mv      <= 1'b0;
            sv      <= 1'b0;
            m_instr <= NOP_INSTR;
        end else if (sv) begin
            // Skid full: no input can fire, only drain skid into main.
            if (out_fire) begin
                m_instr <= s_instr;
                m_pc4   <= s_pc4;
                sv      <= 1'b0;
            end
        end else if (!mv || out_ready) begin
            // Main is empty or leaving this cycle: refill it or insert a bubble.
            if (in_fire) begin
                m_instr <= in_instr;
                m_pc4   <= in_pc4;
                mv      <= 1'b1;
            end else begin
                mv      <= 1'b0;
            end
        end else if (in_fire) begin
            // Decode stalled with main occupied: park the incoming word.
            s_instr <= in_instr;
            s_pc4   <= in_pc4;
            sv      <= 1'b1;
        end
    end

    // Count cycles where decode holds a valid instruction but is stalled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (mv && !out_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: directed scenarios followed by random traffic,
// checked against a queue-based model of a two-deep FIFO slot.
module tb_if_id_skid_reg;

    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc4;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;
    logic [CNT_W-1:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    entry_t      q[$];
    logic [31:0] m_last_pc;
    int          m_cnt;

    if_id_skid_reg #(
        .INSTR_W(32), .PC_W(32), .RESET_PC(32'h0000_3000),
        .NOP_INSTR(32'h0), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc4(in_pc4),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc4(out_pc4),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last_pc = 32'h0000_3000;
        m_cnt     = 0;
    endtask

    // Compare all outputs against the model, then advance one clock.
    task automatic step(input logic r, input logic iv, input logic [31:0] ins,
                        input logic [31:0] pc, input logic fl, input logic ordy);
        bit infire, outfire;
        reset = r; in_valid = iv; in_instr = ins; in_pc4 = pc;
        flush = fl; out_ready = ordy;
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("out_instr", 64'(out_instr), 64'((q.size() > 0) ? q[0].instr : 32'h0));
        chk("out_pc4",   64'(out_pc4),   64'(m_last_pc));
        chk("in_ready",  64'(in_ready),  64'(q.size() < 2));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        @(posedge clk);
        if (!r) begin
            model_reset();
        end else begin
            infire  = iv && (q.size() < 2);
            outfire = (q.size() > 0) && ordy;
            if ((q.size() > 0) && !ordy && !fl && m_cnt != (1 << CNT_W) - 1) m_cnt++;
            if (fl) begin
                q.delete();
            end else begin
                if (outfire) void'(q.pop_front());
                if (infire) q.push_back('{ins, pc});
                if (q.size() > 0) m_last_pc = q[0].pc4;
            end
        end
        #1;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc4 = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // 1. reset state
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_instr", 64'(out_instr), 64'd0);
        chk("rst_pc4",   64'(out_pc4),   64'h3000);
        chk("rst_ready", 64'(in_ready),  64'd1);
        chk("rst_cnt",   64'(stall_cnt), 64'd0);

        // 2. back-to-back stream
        for (int i = 0; i < 4; i++) step(1, 1, 32'h11 + i, 32'h3004 + 4 * i, 0, 1);
        chk("strm_last", 64'(out_instr), 64'h14);
        chk("strm_pc",   64'(out_pc4),   64'h3010);
        repeat (2) step(1, 0, 0, 0, 0, 1);

        // 3. stall with skid catch, then drain in order
        step(1, 1, 32'h21, 32'h3020, 0, 1);
        step(1, 1, 32'h22, 32'h3024, 0, 0);
        step(1, 1, 32'h23, 32'h3028, 0, 0);
        step(1, 1, 32'h23, 32'h3028, 0, 0);
        chk("stall_cnt3", 64'(stall_cnt), 64'd3);
        chk("stall_rdy",  64'(in_ready),  64'd0);
        chk("stall_head", 64'(out_instr), 64'h21);
        step(1, 1, 32'h23, 32'h3028, 0, 1);
        chk("drain_22", 64'(out_instr), 64'h22);
        step(1, 1, 32'h23, 32'h3028, 0, 1);
        chk("drain_23", 64'(out_instr), 64'h23);
        repeat (2) step(1, 0, 0, 0, 0, 1);

        // 4. flush with both entries full, concurrent input dropped
        step(1, 1, 32'h2a, 32'h3030, 0, 1);
        step(1, 1, 32'h2b, 32'h3034, 0, 0);
        step(1, 1, 32'h31, 32'h3038, 1, 0);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_instr", 64'(out_instr), 64'd0);
        chk("fl_ready", 64'(in_ready),  64'd1);
        repeat (3) step(1, 0, 0, 0, 0, 1);

        // 5. counter saturation
        step(1, 1, 32'h41, 32'h3040, 0, 1);
        repeat (20) step(1, 0, 0, 0, 0, 0);
        chk("sat_cnt", 64'(stall_cnt), 64'd15);

        // 6. reset mid-stall with both entries full
        step(1, 1, 32'h51, 32'h3050, 0, 0);
        chk("pre_rst_rdy", 64'(in_ready), 64'd0);
        step(0, 1, 32'h52, 32'h3054, 1, 1);
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_pc4",   64'(out_pc4),   64'h3000);
        chk("mrst_ready", 64'(in_ready),  64'd1);
        chk("mrst_cnt",   64'(stall_cnt), 64'd0);
        repeat (3) step(1, 0, 0, 0, 0, 1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(63) != 0), $urandom_range(1), $urandom,
                 $urandom, ($urandom_range(15) == 0), ($urandom_range(2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
